instr_decode_onehot_stage: RTL and testbench

//  Decode stage feeding the operand-select muxes: takes the fetched 32-bit instruction, emits the
//  20-bit one-hot op vector plus register fields and extended immediate to the operand/execute stage.

---
 rtl/instr_decode_onehot_stage.sv | 161 ++++++++++++++++
 tb/tb_instr_decode_onehot_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_onehot_stage.sv
// Decode stage between fetch and the operand-select muxes.
// It turns a 32-bit instruction into a one-hot op vector, register fields and an extended
// immediate. It has valid/ready on both sides, a 2-entry skid buffer behind a registered
// in_ready, and a RUN/HALTED state machine driven by HALT instructions and the resume pulse.
module instr_decode_onehot_stage #(
  parameter int OPW  = 5,
  parameter int NOPS = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     in_instr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            resume,
  output logic [NOPS-1:0] out_sel,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic            out_illegal,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted
);

  localparam int OP_NOP   = 11;
  localparam int OP_MOVEI = 13;
  localparam int OP_HALT  = 17;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [NOPS-1:0] sel;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            illegal;
  } decoded_t;

  // Pure decode of one stored word. Illegal opcodes become a NOP with the illegal flag set.
  function automatic decoded_t decodeWord(input logic [31:0] word);
    decoded_t       d;
    logic [OPW-1:0] op;
    op        = word[31 -: OPW];
    d.illegal = (int'(op) >= NOPS);
    d.sel     = d.illegal ? (NOPS'(1) << OP_NOP) : (NOPS'(1) << op);
    d.rd      = word[26:22];
    d.rs1     = word[21:17];
    d.rs2     = word[16:12];
    d.imm     = (int'(op) == OP_MOVEI) ? {15'd0, word[16:0]} : {{15{word[16]}}, word[16:0]};
    return d;
  endfunction

  state_t      state_q, state_d;
  logic        inReady_q, inReady_d;
  logic        outValid_q, outValid_d;
  decoded_t    outFields_q, outFields_d;
  logic [31:0] skid0_q, skid0_d;
  logic [31:0] skid1_q, skid1_d;
  logic [1:0]  skidCount_q, skidCount_d;

  logic        accept;
  logic        load;
  logic [31:0] pend0, pend1, pend2;
  logic [1:0]  pendCount;

  // Lines up the held words plus any newly accepted word as one ordered list, hands the
  // oldest to the output register when it is free, and keeps the rest in the skid buffer.
  // Registered in_ready guarantees no accept arrives while both skid entries are occupied.
  always_comb begin
    state_d     = state_q;
    outValid_d  = outValid_q;
    outFields_d = outFields_q;
    skid0_d     = skid0_q;
    skid1_d     = skid1_q;
    skidCount_d = skidCount_q;

    accept = in_valid && inReady_q;
    load   = !outValid_q || out_ready;

    pend0 = skid0_q;
    pend1 = skid1_q;
    pend2 = '0;
    case (skidCount_q)
      2'd0:    pend0 = accept ? in_instr : skid0_q;
      2'd1:    pend1 = accept ? in_instr : skid1_q;
      default: pend2 = in_instr;
    endcase
    pendCount = skidCount_q + (accept ? 2'd1 : 2'd0);

    if (flush) begin
      outValid_d          = 1'b0;
      outFields_d.illegal = 1'b0;
      skidCount_d         = 2'd0;
    end else begin
      if (load) begin
        if (pendCount != 2'd0) begin
          outValid_d  = 1'b1;
          outFields_d = decodeWord(pend0);
          skid0_d     = pend1;
          skid1_d     = pend2;
          skidCount_d = pendCount - 2'd1;
        end else begin
          outValid_d          = 1'b0;
          outFields_d.illegal = 1'b0;
        end
      end else begin
        skid0_d     = pend0;
        skid1_d     = pend1;
        skidCount_d = pendCount;
      end

      if (state_q == HALTED) begin
        if (resume) begin
          state_d = RUN;
        end
      end else if (accept && (int'(in_instr[31 -: OPW]) == OP_HALT)) begin
        state_d = HALTED;
      end
    end

    inReady_d = (state_d == RUN) && (skidCount_d < 2'd2);
  end

  // All stage state, including the RUN/HALTED machine and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      inReady_q   <= 1'b0;
      outValid_q  <= 1'b0;
      outFields_q <= '0;
      skid0_q     <= '0;
      skid1_q     <= '0;
      skidCount_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      inReady_q   <= inReady_d;
      outValid_q  <= outValid_d;
      outFields_q <= outFields_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      skidCount_q <= skidCount_d;
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = outValid_q;
  assign out_sel     = outFields_q.sel;
  assign out_rd      = outFields_q.rd;
  assign out_rs1     = outFields_q.rs1;
  assign out_rs2     = outFields_q.rs2;
  assign out_imm     = outFields_q.imm;
  assign out_illegal = outFields_q.illegal;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_decode_onehot_stage.sv
// Bench for instr_decode_onehot_stage: a queue-based reference of the stage's contents is
// checked on every cycle, alongside directed scenarios with hand-computed literal values.
module tb_instr_decode_onehot_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        resume;
  logic [19:0] out_sel;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic        out_valid;
  logic        out_ready;
  logic        halted;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] modelQ[$];
  logic        haltedM   = 1'b0;
  logic        justReset = 1'b1;

  instr_decode_onehot_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .resume      (resume),
    .out_sel     (out_sel),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Single comparison point shared by the reference checker and the directed scenarios.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference decode rules expressed as plain arithmetic on the opcode number.
  function automatic logic [31:0] expSel(input logic [31:0] w);
    int op;
    op = int'(w[31:27]);
    if (op < 20) return 32'(2 ** op);
    return 32'(2 ** 11);
  endfunction

  function automatic logic [31:0] expImm(input logic [31:0] w);
    int v;
    v = int'(w & 32'h0001FFFF);
    if (int'(w[31:27]) != 13 && v >= 65536) v = v - 131072;
    return 32'(v);
  endfunction

  // Every cycle: the stage holds an ordered list of words; the oldest must be on the output,
  // in_ready must reflect room (fewer than 3 held) and not-halted. Then apply this cycle's events.
  always @(negedge clk) begin
    logic [31:0] w;
    logic        wasHalted;
    if (reset) begin
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_out_sel", 32'(out_sel), 32'd0);
      modelQ.delete();
      haltedM   = 1'b0;
      justReset = 1'b1;
    end else begin
      checkOutput("out_valid", 32'(out_valid), 32'(modelQ.size() != 0));
      if (out_valid && modelQ.size() != 0) begin
        w = modelQ[0];
        checkOutput("out_sel", 32'(out_sel), expSel(w));
        checkOutput("out_rd", 32'(out_rd), 32'(w[26:22]));
        checkOutput("out_rs1", 32'(out_rs1), 32'(w[21:17]));
        checkOutput("out_rs2", 32'(out_rs2), 32'(w[16:12]));
        checkOutput("out_imm", out_imm, expImm(w));
        checkOutput("out_illegal", 32'(out_illegal), 32'(int'(w[31:27]) >= 20));
      end
      checkOutput("halted", 32'(halted), 32'(haltedM));
      if (!justReset)
        checkOutput("in_ready", 32'(in_ready), 32'(!haltedM && modelQ.size() < 3));
      justReset = 1'b0;

      if (flush) begin
        modelQ.delete();
      end else begin
        wasHalted = haltedM;
        if (out_valid && out_ready && modelQ.size() != 0) void'(modelQ.pop_front());
        if (in_valid && in_ready) begin
          modelQ.push_back(in_instr);
          if (int'(in_instr[31:27]) == 17) haltedM = 1'b1;
        end
        if (wasHalted && resume) haltedM = 1'b0;
      end
    end
  end

  // Offer one word and hold it until the stage takes it, returning just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] w);
    int   guard;
    logic acc;
    guard    = 0;
    acc      = 1'b0;
    in_instr = w;
    in_valid = 1'b1;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: word %h not accepted within 50 cycles", w);
    end
    in_valid = 1'b0;
  endtask

  // With the output stalled, keep offering tagged ADDs and count how many the stage absorbs.
  task automatic fillStalled(output int accepted);
    int   tag;
    logic acc;
    accepted  = 0;
    tag       = 1;
    out_ready = 1'b0;
    in_instr  = 32'(tag) << 22;
    in_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        accepted++;
        tag++;
        in_instr = 32'(tag) << 22;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          accepted;
    int          beats;
    logic [4:0]  rdSeen[3];

    reset     = 1'b1;
    in_instr  = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    resume    = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("in_ready_low_at_release", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("in_ready_rises_after_reset", 32'(in_ready), 32'd1);

    // Stream every opcode; HALT pauses the stream until resume lets a held SUB through.
    for (int op = 0; op < 20; op++) begin
      applyStimulus(32'(op) << 27);
      checkOutput("stream_sel", 32'(out_sel), 32'd1 << op);
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      if (op == 17) begin
        checkOutput("halt_halted", 32'(halted), 32'd1);
        in_instr = 32'h0800_0000;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("halt_in_ready", 32'(in_ready), 32'd0);
        checkOutput("halt_drained", 32'(out_valid), 32'd0);
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        checkOutput("resume_in_ready", 32'(in_ready), 32'd1);
        checkOutput("resume_halted", 32'(halted), 32'd0);
        applyStimulus(32'h0800_0000);
        checkOutput("sub_after_resume", 32'(out_sel), 32'h0000_0002);
      end
    end

    applyStimulus(32'h4A7F_FFFF);
    checkOutput("addi_sel", 32'(out_sel), 32'h0000_0200);
    checkOutput("addi_rd", 32'(out_rd), 32'd9);
    checkOutput("addi_rs1", 32'(out_rs1), 32'd31);
    checkOutput("addi_rs2", 32'(out_rs2), 32'd31);
    checkOutput("addi_imm", out_imm, 32'hFFFF_FFFF);
    applyStimulus(32'h6A7F_FFFF);
    checkOutput("movei_sel", 32'(out_sel), 32'h0000_2000);
    checkOutput("movei_imm", out_imm, 32'h0001_FFFF);

    applyStimulus(32'hC800_0000);
    checkOutput("illegal_sel", 32'(out_sel), 32'h0000_0800);
    checkOutput("illegal_flag", 32'(out_illegal), 32'd1);
    applyStimulus(32'h0000_0000);
    checkOutput("legal_after_illegal", 32'(out_illegal), 32'd0);
    checkOutput("legal_after_illegal_sel", 32'(out_sel), 32'h0000_0001);
    repeat (2) @(posedge clk);
    #1;

    fillStalled(accepted);
    checkOutput("stall_accepted", 32'(accepted), 32'd3);
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    beats     = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (beats < 3) rdSeen[beats] = out_rd;
        beats++;
      end
    end
    checkOutput("drain_beats", 32'(beats), 32'd3);
    checkOutput("drain_order0", 32'(rdSeen[0]), 32'd1);
    checkOutput("drain_order1", 32'(rdSeen[1]), 32'd2);
    checkOutput("drain_order2", 32'(rdSeen[2]), 32'd3);
    @(posedge clk);
    #1;

    fillStalled(accepted);
    checkOutput("flush_fill", 32'(accepted), 32'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0000_0000;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush_no_stale", 32'(out_valid), 32'd0);

    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h8800_0000;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_drops_halt", 32'(halted), 32'd0);
    checkOutput("flush_drops_word", 32'(out_valid), 32'd0);

    applyStimulus(32'h8800_0000);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_keeps_halted", 32'(halted), 32'd1);
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    checkOutput("final_resume", 32'(halted), 32'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
